// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter types, defaults and one-hot decode helper
package arb_pkg;
   typedef enum logic {IDLE, GRANT} state_t;
   localparam int N_DEF = 4;
   localparam int MAX_HOLD_DEF = 4;
   // ORing the indices of set bits is an exact decode for a one-hot or zero vector
   function automatic int onehot2idx(input logic [15:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < 16; i++) r = oh[i] ? (r | i) : r;
      return r;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-base priority pick, first set bit of cand above ptr with wrap
//   cand    candidate request vector
//   ptr     last served index; search starts at (ptr+1) mod N
//   win     one-hot winner, zero when none
//   win_idx binary index of winner, zero when none
//   found   1 when cand is nonzero
module rr_pick #(
   parameter int N = 4,
   parameter int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    cand,
   input  logic [IDXW-1:0] ptr,
   output logic [N-1:0]    win,
   output logic [IDXW-1:0] win_idx,
   output logic            found
);
   logic [2*N-1:0] dbl;
   logic [N-1:0] rot;
   logic [IDXW-1:0] j;
   // shifting the doubled vector rotates cand so the search base lands on bit 0
   assign dbl = {cand, cand} >> (ptr + IDXW'(1));
   assign rot = dbl[N-1:0];
   assign found = |rot;
   always_comb begin
      j = '0;
      for (int k = N - 1; k >= 0; k--) j = rot[k] ? IDXW'(k) : j;
   end
   assign win_idx = found ? IDXW'((int'(j) + int'(ptr) + 1) % N) : '0;
   assign win = found ? (N'(1) << win_idx) : '0;
endmodule

// File: rtl/rr_arbiter_4req.sv
// rr_arbiter_4req: registered round-robin arbiter with hold timeout
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   req         request vector, bit held while requester wants/uses resource
//   grant       one-hot registered grant, zero when idle
//   grant_idx   binary index of owner, zero when idle
//   grant_valid 1 while a grant is active
//   expire      one-cycle pulse on the edge a timeout forces release
module rr_arbiter_4req import arb_pkg::*; #(
   parameter int N = N_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF,
   localparam int IDXW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    grant,
   output logic [IDXW-1:0] grant_idx,
   output logic            grant_valid,
   output logic            expire
);
   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   state_t state, state_n;
   logic [IDXW-1:0] ptr, ptr_n, owner, pick_ptr, win_idx, idx_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [N-1:0] cand, win, grant_n;
   logic found, own_req, timeout, exp_n;
   assign owner = IDXW'(onehot2idx(16'(grant)));
   assign own_req = |(req & grant);
   assign timeout = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD - 1));
   // in GRANT the owner is masked so release/timeout hands over to someone else
   assign cand = (state == IDLE) ? req : (req & ~grant);
   assign pick_ptr = (state == IDLE) ? ptr : owner;
   assign grant_valid = (state == GRANT);
   rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
      .cand    (cand),
      .ptr     (pick_ptr),
      .win     (win),
      .win_idx (win_idx),
      .found   (found)
   );
   always_comb begin
      state_n = state;
      grant_n = grant;
      idx_n = grant_idx;
      ptr_n = ptr;
      hold_n = hold_cnt;
      exp_n = 1'b0;
      if (state == IDLE) begin
         state_n = found ? GRANT : IDLE;
         grant_n = found ? win : grant;
         idx_n = found ? win_idx : grant_idx;
         hold_n = found ? '0 : hold_cnt;
      end else if (own_req && !timeout) begin
         hold_n = (MAX_HOLD == 0 && &hold_cnt) ? hold_cnt : hold_cnt + HW'(1);
      end else begin
         ptr_n = owner;
         hold_n = '0;
         exp_n = own_req;
         // no other winner on timeout keeps the owner; on release it goes idle
         state_n = (found || own_req) ? GRANT : IDLE;
         grant_n = found ? win : (own_req ? grant : '0);
         idx_n = found ? win_idx : (own_req ? grant_idx : '0);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         grant_idx <= '0;
         ptr <= IDXW'(N - 1);
         hold_cnt <= '0;
         expire <= 1'b0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         grant_idx <= idx_n;
         ptr <= ptr_n;
         hold_cnt <= hold_n;
         expire <= exp_n;
      end
   end
endmodule

// File: tb/tb_rr_arbiter_4req.sv
// tb_rr_arbiter_4req: randomized + directed check of rr_arbiter_4req against a behavioural model
module tb_rr_arbiter_4req;
   localparam int N = 4;
   localparam int MH = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req = '1;
   logic [N-1:0] grant;
   logic [1:0] grant_idx;
   logic grant_valid, expire;
   int n_cmp = 0;
   int n_bad = 0;
   int m_own, m_ptr, m_held;
   bit m_exp;
   rr_arbiter_4req #(.N(N), .MAX_HOLD(MH)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .expire      (expire)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask
   function automatic int pick(input logic [N-1:0] r, input int from);
      for (int k = 1; k <= N; k++) if (r[(from + k) % N]) return (from + k) % N;
      return -1;
   endfunction
   task automatic model_reset();
      m_own = -1;
      m_ptr = N - 1;
      m_held = 0;
      m_exp = 0;
   endtask
   // m_held counts cycles the current owner has been visible on grant
   task automatic model_edge(input logic [N-1:0] r);
      int w;
      logic [N-1:0] masked;
      m_exp = 0;
      if (m_own < 0) begin
         w = pick(r, m_ptr);
         if (w >= 0) begin
            m_own = w;
            m_held = 1;
         end
      end else if (r[m_own] && m_held < MH) begin
         m_held++;
      end else begin
         m_exp = r[m_own];
         m_ptr = m_own;
         masked = r & ~(N'(1) << m_own);
         w = pick(masked, m_own);
         if (w >= 0) begin
            m_own = w;
            m_held = 1;
         end else if (!r[m_own]) m_own = -1;
         else m_held = 1;
      end
   endtask
   task automatic check_all(input string tag);
      chk({tag, ".grant"}, 32'(grant), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
      chk({tag, ".idx"}, 32'(grant_idx), (m_own < 0) ? 32'd0 : 32'(m_own));
      chk({tag, ".valid"}, 32'(grant_valid), 32'(m_own >= 0));
      chk({tag, ".expire"}, 32'(expire), 32'(m_exp));
   endtask
   task automatic step(input logic [N-1:0] r, input string tag);
      req = r;
      @(posedge clk);
      model_edge(r);
      @(negedge clk);
      check_all(tag);
   endtask
   task automatic pulse_rst(input string tag);
      #2 rst = 1'b1;
      #1 model_reset();
      check_all(tag);
      #1 rst = 1'b0;
   endtask
   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b0;
      step(4'b1111, "first");
      step(4'b0000, "drain");
      step(4'b0000, "idle");
      step(4'b0010, "single");
      step(4'b0010, "single");
      step(4'b0010, "single");
      step(4'b0000, "single_drop");
      for (int o = 0; o < 5; o++) begin
         step(4'b1111, "rot");
         step(4'b1111, "rot");
         step(4'b1111 & ~(4'b0001 << (o % 4)), "rot_rel");
      end
      step(4'b0000, "gap");
      step(4'b0000, "gap");
      for (int i = 0; i < 14; i++) step(4'b0101, "tmo_switch");
      step(4'b0000, "gap");
      for (int i = 0; i < 13; i++) step(4'b1000, "tmo_solo");
      step(4'b0000, "gap");
      step(4'b0100, "pre_rst");
      step(4'b0100, "pre_rst");
      pulse_rst("mid_rst");
      step(4'b0110, "post_rst");
      for (int i = 0; i < 400; i++) begin
         logic [N-1:0] r;
         r = ($urandom_range(0, 3) == 0) ? N'($urandom) : req;
         if ($urandom_range(0, 5) == 0 && m_own >= 0) r[m_own] = 1'b0;
         if ($urandom_range(0, 99) == 0) pulse_rst("rand_rst");
         step(r, "rand");
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/rr_arbiter_4req.md
Name: rr_arbiter_4req

Overview:
- Registered round-robin arbiter that shares one resource among N requesters. The resource is typically an encoder or datapath slot.
- Winner selection uses a rotating-base priority encoder; the resulting grant is held until the owner releases it or a hold timeout expires.
- Sits between requester blocks and the shared resource. It outputs a one-hot grant plus an encoded index and valid flag, in the same style as the team's 4-bit priority encoder (out/valid).

Parameters:
- N, 4, number of requesters (2..16).
- IDXW, $clog2(N), width of grant_idx (derived; do not override).
- MAX_HOLD, 4, maximum consecutive grant cycles per ownership; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  request vector; bit i held high while requester i wants or uses the resource.
- grant  output  N  one-hot registered grant; all zero when idle.
- grant_idx  output  IDXW  binary index of the owner; 0 when idle.
- grant_valid  output  1  1 while any grant is active.
- expire  output  1  one-cycle pulse on the edge where a timeout forces release.

Behaviour:
- Reset (async, immediate): grant=0, grant_idx=0, grant_valid=0, expire=0, state=IDLE, hold_cnt=0, ptr=N-1. With ptr=N-1, req[0] has top priority for the first arbitration.
- Winner function: the first set bit of the candidate vector, searching from (ptr+1) mod N upward with wrap. "None" if the candidate vector is zero.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, at the next edge grant the winner over req.
  - Write grant, grant_idx, grant_valid=1, hold_cnt=0, and go to GRANT.
  - Latency from req sampled high to grant visible is 1 cycle.
- GRANT, owner o, hold continue:
  - Condition: req[o]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD-1).
  - Action: outputs unchanged; hold_cnt increments (saturates when MAX_HOLD=0).
- GRANT, voluntary release (req[o]=0):
  - Set ptr=o and arbitrate over req with bit o masked.
  - Winner exists: grant it on the same edge (back-to-back, no idle bubble); hold_cnt=0.
  - No winner: go to IDLE with grant=0, grant_valid=0, grant_idx=0.
- GRANT, timeout (req[o]=1, MAX_HOLD>0, hold_cnt=MAX_HOLD-1):
  - Set expire=1 for one cycle, ptr=o, and arbitrate over req with bit o masked.
  - Another winner exists: switch to it.
  - No other requester: re-grant o with grant unchanged, hold_cnt=0.
- Requests from non-owners never disturb the current grant.
- Grant is never more than one-hot. grant_idx always equals the encoded grant.
- Outputs are registered only; no combinational path from req to any output.
- A request that drops before being sampled is ignored. There is no request latching.
- Reset asserted mid-grant clears all outputs immediately. Arbitration restarts from req[0] priority after rst deasserts.

Decomposition:
- Shared package arb_pkg holds:
  - the state enum type (IDLE, GRANT);
  - the default N and MAX_HOLD constants;
  - a function for the one-hot-to-index conversion.
- Sub-module rr_pick (combinational): inputs are the candidate vector and ptr; outputs are winner one-hot, winner index and found. It is a rotate, priority-encode, rotate-back structure, reusable by other arbiters.
- Top level: FSM, ptr register, hold counter, output registers.

Test Plan (N=4, MAX_HOLD=4):
- Reset: rst=1 with req=1111 -> grant=0000, grant_idx=0, grant_valid=0, expire=0. Deassert rst with req=1111 -> next edge grant=0001, idx=0.
- Single requester: req=0010 from cycle t -> grant=0010, idx=1, valid=1 at t+1. Drop req at t+3 -> grant=0000, valid=0 at t+4.
- Rotation: req=1111; each owner drops its bit for one cycle after 2 grant cycles, then reasserts -> grant_idx sequence 0,1,2,3,0 with no idle cycles between owners.
- Timeout switch: req=0101 held -> grant=0001 for 4 cycles; expire=1 on the switch edge; then grant=0100 for 4 cycles; then back to 0001.
- Solo timeout: req=1000 held alone -> grant stays 1000 continuously; expire pulses once every 4 cycles.
- Async reset mid-grant: grant=0100 active, pulse rst between edges -> grant=0000 immediately. After release with req=0110 -> grant=0010, because ptr was reset.
